// File: rtl/cp0_exception_unit.sv
// cp0_exception_unit: CP0 exception state (Status/Cause/EPC) with handler entry, ERET return and MFC0/MTC0 access
module cp0_exception_unit #(
   parameter logic [31:0] HANDLER_VECTOR = 32'h0000_0180,
   parameter int          INT_WIDTH      = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ExcReq,
   input  logic                 ExcCause,
   input  logic [31:0]          ExcEPC,
   input  logic [INT_WIDTH-1:0] IntReq,
   input  logic [31:0]          IntPC,
   input  logic                 Eret,
   input  logic                 Mtc0En,
   input  logic [4:0]           C0Addr,
   input  logic [31:0]          C0WrData,
   output logic [31:0]          C0RdData,
   output logic                 Redirect,
   output logic [31:0]          RedirectPC,
   output logic                 IntFlush,
   output logic                 ExcLevel
);

   localparam logic [1:0] ST_NORMAL  = 2'd0;
   localparam logic [1:0] ST_HANDLER = 2'd1;
   localparam logic [1:0] ST_RETURN  = 2'd2;

   localparam logic [4:0] CODE_INT = 5'd0;
   localparam logic [4:0] CODE_RI  = 5'd10;
   localparam logic [4:0] CODE_OV  = 5'd12;

   localparam logic [4:0] ADDR_STATUS = 5'd12;
   localparam logic [4:0] ADDR_CAUSE  = 5'd13;
   localparam logic [4:0] ADDR_EPC    = 5'd14;

   logic [1:0]           state_q, state_d;
   logic [INT_WIDTH-1:0] im_q, im_d;
   logic                 exl_q, exl_d;
   logic                 ie_q, ie_d;
   logic [4:0]           code_q, code_d;
   logic [31:0]          epc_q, epc_d;
   logic [INT_WIDTH-1:0] ip_meta_q, ip_meta_d;
   logic [INT_WIDTH-1:0] ip_q, ip_d;
   logic                 redirect_q, redirect_d;
   logic [31:0]          redirect_pc_q, redirect_pc_d;
   logic                 int_flush_q, int_flush_d;

   logic                 wr_status, wr_cause, wr_epc;
   logic                 int_pending;
   logic [31:0]          status_rd, cause_rd;
   logic                 unused_wr;

   assign wr_status   = Mtc0En && (C0Addr == ADDR_STATUS);
   assign wr_cause    = Mtc0En && (C0Addr == ADDR_CAUSE);
   assign wr_epc      = Mtc0En && (C0Addr == ADDR_EPC);
   assign int_pending = (|(ip_q & im_q)) & ie_q & ~exl_q;
   assign unused_wr   = ^C0WrData;

   // Software writes form the baseline; hardware events below override their own fields.
   always_comb begin
      ip_meta_d     = IntReq;
      ip_d          = ip_meta_q;
      state_d       = state_q;
      im_d          = wr_status ? C0WrData[8 +: INT_WIDTH] : im_q;
      exl_d         = wr_status ? C0WrData[1] : exl_q;
      ie_d          = wr_status ? C0WrData[0] : ie_q;
      code_d        = wr_cause ? C0WrData[6:2] : code_q;
      epc_d         = wr_epc ? C0WrData : epc_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      int_flush_d   = 1'b0;
      if (ExcReq && state_q != ST_HANDLER) begin
         epc_d         = ExcEPC;
         code_d        = ExcCause ? CODE_OV : CODE_RI;
         exl_d         = 1'b1;
         state_d       = ST_HANDLER;
         redirect_d    = 1'b1;
         redirect_pc_d = HANDLER_VECTOR;
      end else if (ExcReq) begin
         code_d        = ExcCause ? CODE_OV : CODE_RI;
         redirect_d    = 1'b1;
         redirect_pc_d = HANDLER_VECTOR;
      end else if (int_pending && state_q == ST_NORMAL) begin
         epc_d         = IntPC;
         code_d        = CODE_INT;
         exl_d         = 1'b1;
         state_d       = ST_HANDLER;
         redirect_d    = 1'b1;
         redirect_pc_d = HANDLER_VECTOR;
         int_flush_d   = 1'b1;
      end else if (Eret && state_q == ST_HANDLER) begin
         state_d       = ST_RETURN;
         redirect_d    = 1'b1;
         redirect_pc_d = epc_d;
      end else if (state_q != ST_NORMAL && state_q != ST_HANDLER) begin
         exl_d         = 1'b0;
         state_d       = ST_NORMAL;
      end
   end

   // All architectural state, synchronizer and output pulses, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_NORMAL;
         im_q          <= '0;
         exl_q         <= 1'b0;
         ie_q          <= 1'b0;
         code_q        <= '0;
         epc_q         <= '0;
         ip_meta_q     <= '0;
         ip_q          <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         int_flush_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         im_q          <= im_d;
         exl_q         <= exl_d;
         ie_q          <= ie_d;
         code_q        <= code_d;
         epc_q         <= epc_d;
         ip_meta_q     <= ip_meta_d;
         ip_q          <= ip_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         int_flush_q   <= int_flush_d;
      end
   end

   // MFC0 read mux over the current register contents.
   always_comb begin
      status_rd                  = '0;
      status_rd[8 +: INT_WIDTH]  = im_q;
      status_rd[1]               = exl_q;
      status_rd[0]               = ie_q;
      cause_rd                   = '0;
      cause_rd[8 +: INT_WIDTH]   = ip_q;
      cause_rd[6:2]              = code_q;
      C0RdData = (C0Addr == ADDR_STATUS) ? status_rd :
                 (C0Addr == ADDR_CAUSE)  ? cause_rd  :
                 (C0Addr == ADDR_EPC)    ? epc_q     : '0;
   end

   assign Redirect   = redirect_q;
   assign RedirectPC = redirect_pc_q;
   assign IntFlush   = int_flush_q;
   assign ExcLevel   = exl_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb_cp0_exception_unit: directed stimulus with a per-cycle reference model and literal spot checks
module tb_cp0_exception_unit;

   localparam logic [31:0] VEC = 32'h0000_0180;
   localparam int          W   = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ExcReq, ExcCause, Eret, Mtc0En;
   logic [31:0]   ExcEPC, IntPC, C0WrData;
   logic [W-1:0]  IntReq;
   logic [4:0]    C0Addr;
   logic [31:0]   C0RdData, RedirectPC;
   logic          Redirect, IntFlush, ExcLevel;

   int errors = 0;
   int checks = 0;
   int nred;

   bit            m_in_handler, m_returning;
   logic [31:0]   m_epc;
   logic [4:0]    m_code;
   logic          m_exl, m_ie;
   logic [W-1:0]  m_im;
   logic [W-1:0]  m_sync [2];
   logic          e_redir, e_flush;
   logic [31:0]   e_pc;

   always #5 clk = ~clk;

   cp0_exception_unit #(.HANDLER_VECTOR(VEC), .INT_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .ExcReq(ExcReq), .ExcCause(ExcCause), .ExcEPC(ExcEPC),
      .IntReq(IntReq), .IntPC(IntPC), .Eret(Eret), .Mtc0En(Mtc0En), .C0Addr(C0Addr),
      .C0WrData(C0WrData), .C0RdData(C0RdData), .Redirect(Redirect), .RedirectPC(RedirectPC),
      .IntFlush(IntFlush), .ExcLevel(ExcLevel)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      logic [31:0] r;
      r = '0;
      if (a == 5'd12) begin
         r[8 +: W] = m_im;
         r[1] = m_exl;
         r[0] = m_ie;
      end else if (a == 5'd13) begin
         r[8 +: W] = m_sync[1];
         r[6:2] = m_code;
      end else if (a == 5'd14) r = m_epc;
      return r;
   endfunction

   task automatic model_reset();
      m_in_handler = 0; m_returning = 0;
      m_epc = '0; m_code = '0; m_exl = 0; m_ie = 0; m_im = '0;
      m_sync[0] = '0; m_sync[1] = '0;
      e_redir = 0; e_flush = 0; e_pc = '0;
   endtask

   task automatic model_step();
      bit pending;
      pending = (|(m_sync[1] & m_im)) && m_ie && !m_exl;
      e_redir = 0;
      e_flush = 0;
      if (Mtc0En && C0Addr == 5'd12) begin
         m_im = C0WrData[8 +: W]; m_exl = C0WrData[1]; m_ie = C0WrData[0];
      end
      if (Mtc0En && C0Addr == 5'd13) m_code = C0WrData[6:2];
      if (Mtc0En && C0Addr == 5'd14) m_epc = C0WrData;
      if (ExcReq && !m_in_handler) begin
         m_epc = ExcEPC; m_code = ExcCause ? 5'd12 : 5'd10; m_exl = 1;
         m_in_handler = 1; m_returning = 0; e_redir = 1; e_pc = VEC;
      end else if (ExcReq) begin
         m_code = ExcCause ? 5'd12 : 5'd10; e_redir = 1; e_pc = VEC;
      end else if (pending && !m_in_handler && !m_returning) begin
         m_epc = IntPC; m_code = 5'd0; m_exl = 1;
         m_in_handler = 1; e_redir = 1; e_flush = 1; e_pc = VEC;
      end else if (Eret && m_in_handler) begin
         m_in_handler = 0; m_returning = 1; e_redir = 1; e_pc = m_epc;
      end else if (m_returning) begin
         m_returning = 0; m_exl = 0;
      end
      m_sync[1] = m_sync[0];
      m_sync[0] = IntReq;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      chk("redirect", 32'(Redirect), 32'(e_redir));
      if (e_redir) chk("redirect_pc", RedirectPC, e_pc);
      chk("int_flush", 32'(IntFlush), 32'(e_flush));
      chk("exc_level", 32'(ExcLevel), 32'(m_exl));
      chk("c0_rd", C0RdData, m_read(C0Addr));
   endtask

   task automatic idle();
      ExcReq = 0; ExcCause = 0; Eret = 0; Mtc0En = 0; C0WrData = '0;
   endtask

   initial begin
      idle();
      ExcEPC = '0; IntPC = '0; IntReq = '0; C0Addr = 5'd14;
      model_reset();
      cyc();
      chk("rst_redirect", 32'(Redirect), 32'd0);
      chk("rst_redirect_pc", RedirectPC, 32'd0);
      chk("rst_flush", 32'(IntFlush), 32'd0);
      chk("rst_exl", 32'(ExcLevel), 32'd0);
      chk("rst_epc", C0RdData, 32'd0);
      cyc();
      #2 rst_n = 1;
      cyc();

      ExcReq = 1; ExcCause = 1; ExcEPC = 32'h40;
      cyc();
      chk("ov_redirect", 32'(Redirect), 32'd1);
      chk("ov_pc", RedirectPC, VEC);
      chk("ov_exl", 32'(ExcLevel), 32'd1);
      idle(); C0Addr = 5'd14;
      cyc();
      chk("ov_single_pulse", 32'(Redirect), 32'd0);
      chk("ov_epc", C0RdData, 32'h40);
      C0Addr = 5'd13;
      cyc();
      chk("ov_code", 32'(C0RdData[6:2]), 32'd12);
      Eret = 1;
      cyc();
      chk("ov_eret_pc", RedirectPC, 32'h40);
      idle();
      cyc();
      cyc();

      ExcReq = 1; ExcCause = 0; ExcEPC = 32'h80;
      cyc();
      idle(); C0Addr = 5'd13;
      cyc();
      chk("ud_code", 32'(C0RdData[6:2]), 32'd10);
      Eret = 1;
      cyc();
      chk("ud_eret_redirect", 32'(Redirect), 32'd1);
      chk("ud_eret_pc", RedirectPC, 32'h80);
      Eret = 0;
      cyc();
      chk("ud_exl_clear", 32'(ExcLevel), 32'd0);
      chk("ud_no_redirect", 32'(Redirect), 32'd0);
      cyc();

      Mtc0En = 1; C0Addr = 5'd12; C0WrData = 32'h101;
      cyc();
      idle();
      chk("status_rd", C0RdData, 32'h101);
      IntReq = 4'b0001; IntPC = 32'h200;
      cyc();
      chk("int_e1", 32'(Redirect), 32'd0);
      cyc();
      chk("int_e2", 32'(Redirect), 32'd0);
      cyc();
      chk("int_e3_redirect", 32'(Redirect), 32'd1);
      chk("int_e3_flush", 32'(IntFlush), 32'd1);
      chk("int_e3_pc", RedirectPC, VEC);
      IntReq = '0; C0Addr = 5'd14;
      cyc();
      chk("int_epc", C0RdData, 32'h200);
      C0Addr = 5'd13;
      cyc();
      chk("int_code", 32'(C0RdData[6:2]), 32'd0);
      Eret = 1;
      cyc();
      idle();
      cyc();
      cyc();

      Mtc0En = 1; C0Addr = 5'd12; C0WrData = 32'h100;
      cyc();
      idle();
      IntReq = 4'b0001;
      nred = 0;
      repeat (8) begin
         cyc();
         if (Redirect) nred++;
      end
      chk("ie0_no_redirect", 32'(nred), 32'd0);
      IntReq = '0;
      repeat (3) cyc();

      ExcReq = 1; ExcCause = 1; ExcEPC = 32'h40;
      cyc();
      idle();
      cyc();
      ExcReq = 1; ExcCause = 0; ExcEPC = 32'h184;
      cyc();
      chk("nest_redirect", 32'(Redirect), 32'd1);
      chk("nest_pc", RedirectPC, VEC);
      idle(); C0Addr = 5'd14;
      cyc();
      chk("nest_epc", C0RdData, 32'h40);
      C0Addr = 5'd13;
      cyc();
      chk("nest_code", 32'(C0RdData[6:2]), 32'd10);
      chk("nest_exl", 32'(ExcLevel), 32'd1);
      Mtc0En = 1; C0Addr = 5'd14; C0WrData = 32'h1234; Eret = 1;
      cyc();
      chk("eret_new_epc", RedirectPC, 32'h1234);
      idle();
      cyc();
      cyc();

      Mtc0En = 1; C0Addr = 5'd12; C0WrData = 32'h101;
      cyc();
      idle();
      IntReq = 4'b0001; IntPC = 32'h200;
      cyc();
      cyc();
      ExcReq = 1; ExcCause = 1; ExcEPC = 32'h300;
      cyc();
      chk("col_redirect", 32'(Redirect), 32'd1);
      chk("col_no_flush", 32'(IntFlush), 32'd0);
      idle(); C0Addr = 5'd14;
      cyc();
      chk("col_epc", C0RdData, 32'h300);
      Eret = 1;
      cyc();
      chk("col_eret_pc", RedirectPC, 32'h300);
      idle();
      cyc();
      cyc();
      chk("col_int_follows", 32'(Redirect), 32'd1);
      chk("col_int_flush", 32'(IntFlush), 32'd1);
      IntReq = '0;
      repeat (3) cyc();
      Eret = 1;
      cyc();
      idle();
      cyc();
      cyc();
      Mtc0En = 1; C0Addr = 5'd12; C0WrData = 32'h0;
      cyc();
      idle();

      Mtc0En = 1; C0Addr = 5'd14; C0WrData = 32'hDEAD_BEEF;
      ExcReq = 1; ExcCause = 0; ExcEPC = 32'h500;
      cyc();
      idle();
      chk("mtc0_vs_exc", C0RdData, 32'h500);
      Eret = 1;
      cyc();
      idle();
      cyc();
      cyc();

      Mtc0En = 1; C0Addr = 5'd5; C0WrData = 32'hFFFF_FFFF;
      cyc();
      idle();
      chk("unmapped_rd", C0RdData, 32'd0);
      Mtc0En = 1; C0Addr = 5'd13; C0WrData = 32'hFFFF_FFFF;
      cyc();
      idle();
      chk("cause_wr_code_only", C0RdData, 32'h7C);

      Eret = 1;
      cyc();
      chk("eret_normal", 32'(Redirect), 32'd0);
      idle();
      cyc();

      ExcReq = 1; ExcCause = 1; ExcEPC = 32'h40;
      cyc();
      idle();
      #2 rst_n = 0;
      #1;
      chk("arst_redirect", 32'(Redirect), 32'd0);
      chk("arst_pc", RedirectPC, 32'd0);
      chk("arst_exl", 32'(ExcLevel), 32'd0);
      chk("arst_flush", 32'(IntFlush), 32'd0);
      cyc();
      cyc();
      #2 rst_n = 1;
      Eret = 1; C0Addr = 5'd14;
      cyc();
      chk("post_rst_eret", 32'(Redirect), 32'd0);
      chk("post_rst_epc", C0RdData, 32'd0);
      idle();
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
